gpzda_sender: RTL and testbench

- Generates a complete NMEA ZDA sentence, "$GPZDA,hhmmss.ss,dd,mm,yyyy,,*CS\r\n", from BCD time/date fields.
- Emits the sentence one byte per accepted transfer.
- It is the transmit-side counterpart of the GPS receiver: it produces the 34-byte byte stream that the receiver parses.
- The XOR checksum is computed on the fly.

---
 rtl/gpzda_pkg.sv | 59 +++++
 rtl/gpzda_nibble_ascii.sv | 10 +
 rtl/gpzda_sender.sv | 193 +++++++++++++++++++
 tb/tb_gpzda_sender.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpzda_pkg.sv
// Shared constants and types for the NMEA ZDA sender and the matching receiver parser.
package gpzda_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_Z      = 8'h5A;
  localparam logic [7:0] CH_D      = 8'h44;
  localparam logic [7:0] CH_A      = 8'h41;

  localparam int SENTENCE_LEN = 34;

  localparam logic [5:0] IDX_DOLLAR   = 6'd0;
  localparam logic [5:0] IDX_TALKER   = 6'd1;
  localparam logic [5:0] IDX_ZDA      = 6'd3;
  localparam logic [5:0] IDX_HH       = 6'd7;
  localparam logic [5:0] IDX_MM       = 6'd9;
  localparam logic [5:0] IDX_SS       = 6'd11;
  localparam logic [5:0] IDX_DOT      = 6'd13;
  localparam logic [5:0] IDX_CS       = 6'd14;
  localparam logic [5:0] IDX_DD       = 6'd17;
  localparam logic [5:0] IDX_MON      = 6'd20;
  localparam logic [5:0] IDX_YEAR     = 6'd23;
  localparam logic [5:0] IDX_CK_FIRST = 6'd1;
  localparam logic [5:0] IDX_CK_LAST  = 6'd28;
  localparam logic [5:0] IDX_STAR     = 6'd29;
  localparam logic [5:0] IDX_CK_HI    = 6'd30;
  localparam logic [5:0] IDX_CK_LO    = 6'd31;
  localparam logic [5:0] IDX_CR       = 6'd32;
  localparam logic [5:0] IDX_LF       = 6'd33;

  typedef enum logic {IDLE, SEND} state_e;

  typedef struct packed {
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic [7:0]  centi;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
  } zda_fields_t;

  // True when every one of the 16 nibbles is a legal BCD digit.
  function automatic logic fields_bcd(input zda_fields_t f);
    logic [63:0] v;
    logic        ok;
    v  = f;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ok = ok & (v[i*4 +: 4] <= 4'd9);
    end
    return ok;
  endfunction

endpackage

// File: rtl/gpzda_nibble_ascii.sv
// Combinational 4-bit value to ASCII digit: '0'-'9' for 0-9, uppercase 'A'-'F' above.
module gpzda_nibble_ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = (nib_i <= 4'd9) ? (8'h30 | {4'h0, nib_i})
                                   : (8'h37 + {4'h0, nib_i});

endmodule

// File: rtl/gpzda_sender.sv
// Streams "$GPZDA,hhmmss.ss,dd,mm,yyyy,,*CS\r\n" one byte per valid/ready transfer,
// accumulating the XOR checksum as bytes 1..28 are accepted.
module gpzda_sender
  import gpzda_pkg::*;
#(
  parameter int          B      = 8,
  parameter logic [15:0] TALKER = "GP"
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   hour,
  input  logic [7:0]   minute,
  input  logic [7:0]   second,
  input  logic [7:0]   centisecond,
  input  logic [7:0]   day,
  input  logic [7:0]   month,
  input  logic [15:0]  year,
  input  logic         ready,
  output logic [B-1:0] data,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic         error
);

  state_e      state_q, state_d;
  zda_fields_t fields_q, fields_d;
  zda_fields_t in_fields_s;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  nidx_s;
  logic [7:0]  ck_q, ck_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  dig_nib_s;
  logic [3:0]  ck_nib_s;
  logic [7:0]  dig_ascii_s;
  logic [7:0]  ck_ascii_s;
  logic [7:0]  byte_s;
  logic        xfer_s;

  assign in_fields_s = {hour, minute, second, centisecond, day, month, year};
  assign nidx_s      = idx_q + 6'd1;
  assign xfer_s      = valid_q & ready;
  assign ck_nib_s    = (nidx_s == IDX_CK_HI) ? ck_q[7:4] : ck_q[3:0];

  gpzda_nibble_ascii u_dig_ascii (.nib_i(dig_nib_s), .ascii_o(dig_ascii_s));
  gpzda_nibble_ascii u_ck_ascii  (.nib_i(ck_nib_s),  .ascii_o(ck_ascii_s));

  // BCD nibble feeding the digit converter for the byte about to be presented.
  always_comb begin
    dig_nib_s = 4'h0;
    case (nidx_s)
      IDX_HH:             dig_nib_s = fields_q.hour[7:4];
      IDX_HH + 6'd1:      dig_nib_s = fields_q.hour[3:0];
      IDX_MM:             dig_nib_s = fields_q.minute[7:4];
      IDX_MM + 6'd1:      dig_nib_s = fields_q.minute[3:0];
      IDX_SS:             dig_nib_s = fields_q.second[7:4];
      IDX_SS + 6'd1:      dig_nib_s = fields_q.second[3:0];
      IDX_CS:             dig_nib_s = fields_q.centi[7:4];
      IDX_CS + 6'd1:      dig_nib_s = fields_q.centi[3:0];
      IDX_DD:             dig_nib_s = fields_q.day[7:4];
      IDX_DD + 6'd1:      dig_nib_s = fields_q.day[3:0];
      IDX_MON:            dig_nib_s = fields_q.month[7:4];
      IDX_MON + 6'd1:     dig_nib_s = fields_q.month[3:0];
      IDX_YEAR:           dig_nib_s = fields_q.year[15:12];
      IDX_YEAR + 6'd1:    dig_nib_s = fields_q.year[11:8];
      IDX_YEAR + 6'd2:    dig_nib_s = fields_q.year[7:4];
      IDX_YEAR + 6'd3:    dig_nib_s = fields_q.year[3:0];
      default:            dig_nib_s = 4'h0;
    endcase
  end

  // Byte map for the next index; digit positions fall through to the default.
  always_comb begin
    byte_s = dig_ascii_s;
    case (nidx_s)
      IDX_DOLLAR:         byte_s = CH_DOLLAR;
      IDX_TALKER:         byte_s = TALKER[15:8];
      IDX_TALKER + 6'd1:  byte_s = TALKER[7:0];
      IDX_ZDA:            byte_s = CH_Z;
      IDX_ZDA + 6'd1:     byte_s = CH_D;
      IDX_ZDA + 6'd2:     byte_s = CH_A;
      6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd28:
                          byte_s = CH_COMMA;
      IDX_DOT:            byte_s = CH_DOT;
      IDX_STAR:           byte_s = CH_STAR;
      IDX_CK_HI:          byte_s = ck_ascii_s;
      IDX_CK_LO:          byte_s = ck_ascii_s;
      IDX_CR:             byte_s = CH_CR;
      IDX_LF:             byte_s = CH_LF;
      default:            byte_s = dig_ascii_s;
    endcase
  end

  // Next-state logic: the output byte register is loaded one transfer ahead of its index.
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    idx_d    = idx_q;
    ck_d     = ck_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 8'h00;
        if (start) begin
          if (fields_bcd(in_fields_s)) begin
            fields_d = in_fields_s;
            ck_d     = 8'h00;
            idx_d    = IDX_DOLLAR;
            data_d   = CH_DOLLAR;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = SEND;
          end else begin
            error_d  = 1'b1;
          end
        end else begin
          idx_d = IDX_DOLLAR;
        end
      end
      SEND: begin
        if (xfer_s) begin
          if ((idx_q >= IDX_CK_FIRST) && (idx_q <= IDX_CK_LAST)) begin
            ck_d = ck_q ^ data_q;
          end else begin
            ck_d = ck_q;
          end
          if (idx_q == IDX_LF) begin
            state_d = IDLE;
            idx_d   = IDX_DOLLAR;
            data_d  = 8'h00;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = nidx_s;
            data_d  = byte_s;
          end
        end else begin
          data_d = data_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      fields_q <= '0;
      idx_q    <= 6'd0;
      ck_q     <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      idx_q    <= idx_d;
      ck_q     <= ck_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_gpzda_sender.sv
// Self-checking bench for gpzda_sender: start-acceptance table, directed corner sequences,
// and randomized sentences against a string-level reference model.
module tb_gpzda_sender;

  logic        clock = 1'b0;
  logic        reset, start, ready;
  logic [7:0]  hour, minute, second, centisecond, day, month;
  logic [15:0] year;
  logic [7:0]  data;
  logic        valid, busy, done, error;

  typedef struct {
    logic [7:0]  hour, minute, second, centi, day, month;
    logic [15:0] year;
  } fields_t;

  typedef struct {
    fields_t f;
    bit      exp_err;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_b[34];
  logic [7:0] cap_b[34];

  gpzda_sender dut (
    .clock(clock), .reset(reset), .start(start),
    .hour(hour), .minute(minute), .second(second), .centisecond(centisecond),
    .day(day), .month(month), .year(year), .ready(ready),
    .data(data), .valid(valid), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic fields_t nominal();
    fields_t f;
    f.hour = 8'h14; f.minute = 8'h30; f.second = 8'h42; f.centi = 8'h00;
    f.day = 8'h25; f.month = 8'h08; f.year = 16'h2005;
    return f;
  endfunction

  function automatic logic [7:0] rand_bcd8();
    return {4'($urandom_range(9)), 4'($urandom_range(9))};
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.hour = rand_bcd8(); f.minute = rand_bcd8(); f.second = rand_bcd8();
    f.centi = rand_bcd8(); f.day = rand_bcd8(); f.month = rand_bcd8();
    f.year = {rand_bcd8(), rand_bcd8()};
    return f;
  endfunction

  // Reference: BCD printed in hex reads as its decimal digits; checksum over text between '$' and '*'.
  task automatic build_expected(input fields_t f);
    string      s;
    string      cks;
    logic [7:0] ck;
    s = $sformatf("$GPZDA,%02h%02h%02h.%02h,%02h,%02h,%04h,,",
                  f.hour, f.minute, f.second, f.centi, f.day, f.month, f.year);
    ck = 8'h00;
    for (int i = 1; i < s.len(); i++) ck = ck ^ s[i];
    cks = $sformatf("%02h", ck);
    cks = cks.toupper();
    s = {s, "*", cks, "\r\n"};
    for (int i = 0; i < 34; i++) exp_b[i] = s[i];
  endtask

  task automatic apply_fields(input fields_t f);
    hour = f.hour; minute = f.minute; second = f.second; centisecond = f.centi;
    day = f.day; month = f.month; year = f.year;
  endtask

  // Sends one sentence starting at the current negedge and checks every presented byte.
  task automatic run_sentence(input fields_t f, input int stall_pct, input int stall_a,
                              input int stall_b, input bit mid_start, input string tag);
    int n, stalls, busy_cnt, hold_a, hold_b;
    bit rdy;
    build_expected(f);
    apply_fields(f);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0; stalls = 0; busy_cnt = 0; hold_a = 0; hold_b = 0;
    for (int cyc = 0; cyc < 1000 && n < 34; cyc++) begin
      if (busy) busy_cnt++;
      check({tag, " valid"}, 32'(valid), 32'd1);
      check({tag, " data"}, 32'(data), 32'(exp_b[n]));
      check({tag, " done_early"}, 32'(done), 32'd0);
      cap_b[n] = data;
      rdy = 1'b1;
      if (n == stall_a && hold_a < 3) begin
        rdy = 1'b0; hold_a++;
      end else if (n == stall_b && hold_b < 3) begin
        rdy = 1'b0; hold_b++;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        rdy = 1'b0;
      end
      ready = rdy;
      if (mid_start && n == 10) begin
        start = 1'b1;
        apply_fields(rand_fields());
      end
      @(negedge clock);
      start = 1'b0;
      if (rdy) n++; else stalls++;
    end
    check({tag, " complete"}, 32'(n), 32'd34);
    check({tag, " end_valid"}, 32'(valid), 32'd0);
    check({tag, " end_busy"}, 32'(busy), 32'd0);
    check({tag, " end_done"}, 32'(done), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(34 + stalls));
    ready = 1'b1;
  endtask

  task automatic settle(input string tag);
    @(negedge clock);
    check({tag, " done_once"}, 32'(done), 32'd0);
    check({tag, " idle_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    vec_t  vt[6];
    string lit;
    fields_t f;

    lit = "$GPZDA,143042.00,25,08,2005,,*6E\r\n";
    vt[0].f = nominal();                             vt[0].exp_err = 1'b0;
    vt[1].f = nominal(); vt[1].f.minute = 8'h7A;     vt[1].exp_err = 1'b1;
    vt[2].f = nominal(); vt[2].f.hour = 8'h99;       vt[2].exp_err = 1'b0;
    vt[3].f = nominal(); vt[3].f.year = 16'h20A5;    vt[3].exp_err = 1'b1;
    vt[4].f = nominal(); vt[4].f.centi = 8'hF0;      vt[4].exp_err = 1'b1;
    vt[5].f = nominal(); vt[5].f.day = 8'h00; vt[5].f.month = 8'h00; vt[5].f.year = 16'h0000;
    vt[5].exp_err = 1'b0;

    reset = 1'b1; start = 1'b0; ready = 1'b1;
    apply_fields(nominal());
    repeat (2) @(negedge clock);
    check("rst data", 32'(data), 32'h00);
    check("rst valid", 32'(valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Start-acceptance table: accepted starts are aborted with reset once '$' is seen.
    for (int i = 0; i < 6; i++) begin
      apply_fields(vt[i].f);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check($sformatf("vec%0d error", i), 32'(error), 32'(vt[i].exp_err));
      check($sformatf("vec%0d valid", i), 32'(valid), 32'(!vt[i].exp_err));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(!vt[i].exp_err));
      check($sformatf("vec%0d data", i), 32'(data), vt[i].exp_err ? 32'h00 : 32'h24);
      @(negedge clock);
      check($sformatf("vec%0d error_pulse", i), 32'(error), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check($sformatf("vec%0d after_rst", i), 32'(valid), 32'd0);
    end

    // Nominal sentence against the literal text.
    run_sentence(nominal(), 0, -1, -1, 1'b0, "nominal");
    for (int i = 0; i < 34; i++) check($sformatf("nominal lit[%0d]", i), 32'(cap_b[i]), 32'(lit[i]));
    settle("nominal");

    // Backpressure at indices 5 and 30 for three cycles each.
    run_sentence(nominal(), 0, 5, 30, 1'b0, "stall");
    for (int i = 0; i < 34; i++) check($sformatf("stall lit[%0d]", i), 32'(cap_b[i]), 32'(lit[i]));
    settle("stall");

    // Back-to-back: second start lands in the done cycle; mid-sentence start is ignored.
    run_sentence(nominal(), 0, -1, -1, 1'b1, "b2b_a");
    run_sentence(vt[2].f, 0, -1, -1, 1'b0, "b2b_b");
    settle("b2b");

    // Reset at index 15 abandons the sentence without a done pulse.
    build_expected(nominal());
    apply_fields(nominal());
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    check("midrst idx15", 32'(data), 32'(exp_b[15]));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst valid", 32'(valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clock);
    check("midrst no_done", 32'(done), 32'd0);
    run_sentence(nominal(), 0, -1, -1, 1'b0, "post_rst");
    check("post_rst ck_hi", 32'(cap_b[30]), 32'h36);
    check("post_rst ck_lo", 32'(cap_b[31]), 32'h45);
    settle("post_rst");

    // Randomized sentences with random backpressure and occasional back-to-back starts.
    for (int k = 0; k < 10; k++) begin
      f = rand_fields();
      run_sentence(f, 30, -1, -1, k[0], $sformatf("rand%0d", k));
      if ($urandom_range(1) == 0) settle($sformatf("rand%0d", k));
    end
    settle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
